// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS fetch/sequencing logic: sequencer states,
// default sequential PC increment and the HALT opcode value.
package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STEP_WAIT = 3'd2,
        S_STEP_EXEC = 3'd3,
        S_DRAIN     = 3'd4,
        S_HALT      = 3'd5
    } seq_state_t;

    localparam int PC_STEP_BYTES = 4;
    localparam logic [5:0] HALT_OPCODE = 6'h3F;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC target select: taken branch beats jump beats the sequential increment.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int PC_STEP  = PC_STEP_BYTES
) (
    input  logic [PC_WIDTH-1:0] pc_cur_i,
    input  logic                jump_i,
    input  logic [PC_WIDTH-1:0] jump_target_i,
    input  logic                branch_taken_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    logic [PC_WIDTH-1:0] pc_seq;

    // Wraps modulo 2^PC_WIDTH by construction.
    assign pc_seq = pc_cur_i + PC_WIDTH'(PC_STEP);

    always_comb begin
        pc_next_o = pc_seq;
        if (branch_taken_i) begin
            pc_next_o = branch_target_i;
        end else if (jump_i) begin
            pc_next_o = jump_target_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Run/step/halt controller for the program counter: arbitrates fetch, jump,
// taken branch, stall, debug single-step and the HALT drain sequence.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int PC_STEP      = PC_STEP_BYTES,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic                 MODE_STEP,
    input  logic                 STEP_REQ,
    input  logic                 STALL,
    input  logic                 JUMP,
    input  logic [PC_WIDTH-1:0]  JUMP_TARGET,
    input  logic                 BRANCH_TAKEN,
    input  logic [PC_WIDTH-1:0]  BRANCH_TARGET,
    input  logic                 HALT_DETECT,
    input  logic [PC_WIDTH-1:0]  PC_CUR,
    output logic [PC_WIDTH-1:0]  PC_NEXT,
    output logic                 PC_ENABLE,
    output logic                 PC_CTRL,
    output logic                 PIPE_ENABLE,
    output logic                 FLUSH_IF_ID,
    output logic                 FLUSH_ID_EX,
    output logic                 HALTED,
    output logic [2:0]           STATE,
    output logic [CNT_WIDTH-1:0] CYCLE_COUNT
);

    seq_state_t           state_q, state_d;
    logic [3:0]           drain_q, drain_d;
    logic                 step_mode_q, step_mode_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic active;
    logic in_drain;
    logic halt_go;

    pc_next_mux #(
        .PC_WIDTH (PC_WIDTH),
        .PC_STEP  (PC_STEP)
    ) u_pc_next_mux (
        .pc_cur_i        (PC_CUR),
        .jump_i          (JUMP),
        .jump_target_i   (JUMP_TARGET),
        .branch_taken_i  (BRANCH_TAKEN),
        .branch_target_i (BRANCH_TARGET),
        .pc_next_o       (PC_NEXT)
    );

    assign active   = (state_q == S_RUN) || (state_q == S_STEP_EXEC);
    assign in_drain = (state_q == S_DRAIN);
    // A taken branch squashes the HALT that was decoded behind it.
    assign halt_go  = HALT_DETECT && !BRANCH_TAKEN;

    assign PC_ENABLE   = active;
    assign PIPE_ENABLE = active || in_drain;
    assign PC_CTRL     = BRANCH_TAKEN || (!STALL && !HALT_DETECT) || (JUMP && !HALT_DETECT);
    assign FLUSH_IF_ID = (active && (BRANCH_TAKEN || JUMP)) || in_drain;
    assign FLUSH_ID_EX = active && BRANCH_TAKEN;
    assign HALTED      = (state_q == S_HALT);
    assign STATE       = state_q;
    assign CYCLE_COUNT = cnt_q;

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        step_mode_d = step_mode_q;
        cnt_d       = cnt_q;
        if (PIPE_ENABLE && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    step_mode_d = MODE_STEP;
                    state_d     = MODE_STEP ? S_STEP_WAIT : S_RUN;
                end
            end
            S_RUN: begin
                if (halt_go) state_d = S_DRAIN;
            end
            S_STEP_WAIT: begin
                if (STEP_REQ) state_d = S_STEP_EXEC;
            end
            S_STEP_EXEC: begin
                // A stalled step stays here so that each step is exactly one PC update.
                if (halt_go) begin
                    state_d = S_DRAIN;
                end else if (PC_CTRL) begin
                    state_d = step_mode_q ? S_STEP_WAIT : S_RUN;
                end
            end
            S_DRAIN: begin
                if (drain_q == 4'(DRAIN_CYCLES - 1)) begin
                    drain_d = '0;
                    state_d = S_HALT;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            drain_q     <= '0;
            step_mode_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            step_mode_q <= step_mode_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
